// File: rtl/pcie_tx_arb.sv
// pcie_tx_arb: merges read-completion, read-request and posted-write requesters into PCIe TLPs on a 64-bit AXI stream
// Ports:
//   clock, reset_n                 clock and asynchronous active-low reset
//   pcie_id                        requester/completer ID placed in every header
//   rc_valid/rc_rid_tag/rc_lower_addr/rc_data -> rc_ready   completion source (3-beat CplD, 2 DW)
//   rr_valid/rr_addr/rr_tag -> rr_ready                     memory read request source
//   wr_valid/wr_addr/wr_data -> wr_ready                    memory write source, one 64-bit word per wr_ready
//   tx_tready -> tx_tdata/tx_tvalid/tx_tlast/tx_1dw          AXI stream toward the PCIe core, DW0 in [31:0]
module pcie_tx_arb #(
  parameter int WR_PAYLOAD_DW = 32,
  parameter int RR_LENGTH_DW  = 128,
  parameter int ARB_MODE      = 0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] pcie_id,
  input  logic        rc_valid,
  input  logic [23:0] rc_rid_tag,
  input  logic [3:0]  rc_lower_addr,
  input  logic [63:0] rc_data,
  output logic        rc_ready,
  input  logic        rr_valid,
  input  logic [63:0] rr_addr,
  input  logic [7:0]  rr_tag,
  output logic        rr_ready,
  input  logic        wr_valid,
  input  logic [63:0] wr_addr,
  input  logic [63:0] wr_data,
  output logic        wr_ready,
  input  logic        tx_tready,
  output logic [63:0] tx_tdata,
  output logic        tx_1dw,
  output logic        tx_tlast,
  output logic        tx_tvalid
);
  // Each state names the beat that is loaded into the output registers on the next advance.
  // IDLE loads either a header (arbitration) or an empty beat.
  typedef enum logic [2:0] {IDLE, RC2, RC3, RR2, WA, WD, WT} state_t;
  localparam logic [9:0] WR_LEN  = 10'(WR_PAYLOAD_DW % 1024);
  localparam logic [9:0] RR_LEN  = 10'(RR_LENGTH_DW % 1024);
  localparam logic [9:0] WD_LAST = 10'(WR_PAYLOAD_DW / 2 - 1);
  state_t state, state_nx;
  logic [9:0] cnt;
  logic [31:0] hold;
  logic [1:0] prio, s1, s2, grant;
  logic [2:0] req;
  logic adv, any, rr_4dw, wr_4dw, wd_last;
  logic [63:0] hdr, tdata_nx;
  logic tlast_nx, t1dw_nx;

  function automatic logic [31:0] es(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  function automatic logic [1:0] inc3(input logic [1:0] p);
    return p == 2'd2 ? 2'd0 : p + 2'd1;
  endfunction

  assign adv     = tx_tready | ~tx_tvalid;
  assign req     = {wr_valid, rr_valid, rc_valid};
  assign any     = |req;
  assign s1      = inc3(prio);
  assign s2      = inc3(s1);
  // prio stays at rc in fixed mode, so the same rotation gives rc > rr > wr
  assign grant   = req[prio] ? prio : req[s1] ? s1 : s2;
  assign rr_4dw  = |rr_addr[63:32];
  assign wr_4dw  = |wr_addr[63:32];
  assign wd_last = cnt == WD_LAST;
  assign rc_ready = adv && state == RC3;
  assign rr_ready = adv && state == RR2;
  assign wr_ready = adv && state == WD;
  assign hdr = grant == 2'd0 ? {pcie_id, 16'd8, 32'h4A00_0002}
             : grant == 2'd1 ? {pcie_id, rr_tag, 8'hFF, 2'b00, rr_4dw, 19'd0, RR_LEN}
             :                 {pcie_id, 16'h00FF, 2'b01, wr_4dw, 19'd0, WR_LEN};

  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      hold      <= '0;
      prio      <= '0;
      tx_tdata  <= '0;
      tx_tvalid <= 1'b0;
      tx_tlast  <= 1'b0;
      tx_1dw    <= 1'b0;
    end else if (adv) begin
      state     <= state_nx;
      cnt       <= state == WD ? cnt + 10'd1 : 10'd0;
      if (state == WD) hold <= es(wr_data[63:32]);
      if (ARB_MODE != 0 && state == IDLE && any) prio <= inc3(grant);
      tx_tdata  <= tdata_nx;
      tx_tvalid <= state != IDLE || any;
      tx_tlast  <= tlast_nx;
      tx_1dw    <= t1dw_nx;
    end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = !any ? IDLE : grant == 2'd0 ? RC2 : grant == 2'd1 ? RR2 : wr_4dw ? WA : WD;
      RC2:     state_nx = RC3;
      RC3:     state_nx = IDLE;
      RR2:     state_nx = IDLE;
      WA:      state_nx = WD;
      WD:      state_nx = !wd_last ? WD : wr_4dw ? IDLE : WT;
      WT:      state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    tdata_nx = '0;
    tlast_nx = 1'b0;
    t1dw_nx  = 1'b0;
    case (state)
      IDLE: tdata_nx = any ? hdr : '0;
      RC2:  tdata_nx = {es(rc_data[31:0]), rc_rid_tag, 1'b0, rc_lower_addr, 3'b000};
      RC3: begin
        tdata_nx = {32'd0, es(rc_data[63:32])};
        tlast_nx = 1'b1;
        t1dw_nx  = 1'b1;
      end
      RR2: begin
        tdata_nx = rr_4dw ? {rr_addr[31:0], rr_addr[63:32]} : {32'd0, rr_addr[31:0]};
        tlast_nx = 1'b1;
        t1dw_nx  = ~rr_4dw;
      end
      WA:   tdata_nx = {wr_addr[31:0], wr_addr[63:32]};
      // 3DW writes are shifted by one DW: the address fills the first low lane, then the held high half
      WD: begin
        tdata_nx = wr_4dw ? {es(wr_data[63:32]), es(wr_data[31:0])}
                          : {es(wr_data[31:0]), cnt == 10'd0 ? wr_addr[31:0] : hold};
        tlast_nx = wr_4dw && wd_last;
      end
      WT: begin
        tdata_nx = {32'd0, hold};
        tlast_nx = 1'b1;
        t1dw_nx  = 1'b1;
      end
      default: tdata_nx = '0;
    endcase
  end
endmodule

// File: tb/tb_pcie_tx_arb.sv
// tb_pcie_tx_arb: checks pcie_tx_arb (fixed-priority and round-robin instances) against a TLP-queue model
module tb_pcie_tx_arb;
  localparam int WR_DW = 4;
  localparam int RR_DW = 128;
  typedef struct packed {logic [63:0] d; logic v; logic l; logic o; logic [1:0] r;} beat_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic [15:0] pcie_id = 16'h0100;
  logic rc_valid = 1'b0, rr_valid = 1'b0, wr_valid = 1'b0, tx_tready = 1'b1;
  logic [23:0] rc_rid_tag = '0;
  logic [3:0] rc_lower_addr = '0;
  logic [63:0] rc_data = '0, rr_addr = '0, wr_addr = '0, wr_data;
  logic [7:0] rr_tag = '0;
  logic [63:0] td [2];
  logic tv [2], tl [2], t1 [2], rcr [2], rrr [2], wrr [2];
  logic [63:0] wr_tab [8];
  int drv_idx = 0;
  logic take = 1'b0;
  int tests = 0, fail = 0;
  beat_t q [2][$];
  beat_t cur [2];
  int prio [2];
  int widx [2];
  logic sop [2];
  logic [63:0] acc [$];
  logic [1:0] accf [$];
  logic [31:0] hdr0 [$], hdr1 [$];
  int nrc = 0, nrr = 0, nwr = 0;

  always #5 clock = ~clock;
  assign wr_data = wr_tab[drv_idx % 8];

  for (genvar i = 0; i < 2; i++) begin : g_dut
    pcie_tx_arb #(.WR_PAYLOAD_DW(WR_DW), .RR_LENGTH_DW(RR_DW), .ARB_MODE(i)) dut (
      .clock(clock), .reset_n(reset_n), .pcie_id(pcie_id),
      .rc_valid(rc_valid), .rc_rid_tag(rc_rid_tag), .rc_lower_addr(rc_lower_addr), .rc_data(rc_data), .rc_ready(rcr[i]),
      .rr_valid(rr_valid), .rr_addr(rr_addr), .rr_tag(rr_tag), .rr_ready(rrr[i]),
      .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wrr[i]),
      .tx_tready(tx_tready), .tx_tdata(td[i]), .tx_1dw(t1[i]), .tx_tlast(tl[i]), .tx_tvalid(tv[i]));
  end

  function automatic logic [31:0] es(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  function automatic beat_t mk(input logic [63:0] d, input logic l, input logic o, input logic [1:0] r);
    return {d, 1'b1, l, o, r};
  endfunction

  task automatic chk(input string nm, input logic [66:0] act, input logic [66:0] exp);
    tests++;
    if (act !== exp) begin
      fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic int pick(input int m);
    logic [2:0] v = {wr_valid, rr_valid, rc_valid};
    for (int k = 0; k < 3; k++)
      if (v[(prio[m] + k) % 3]) return (prio[m] + k) % 3;
    return 0;
  endfunction

  // Whole TLP pushed at grant time; r marks which ready must pulse when that beat loads.
  task automatic build(input int m, input int g);
    logic [63:0] d, p;
    logic h4;
    int n = WR_DW / 2;
    p = '0;
    if (g == 0) begin
      q[m].push_back(mk({pcie_id, 16'd8, 32'h4A000002}, 0, 0, 0));
      q[m].push_back(mk({es(rc_data[31:0]), rc_rid_tag, 1'b0, rc_lower_addr, 3'b0}, 0, 0, 0));
      q[m].push_back(mk({32'd0, es(rc_data[63:32])}, 1, 1, 1));
    end else if (g == 1) begin
      h4 = |rr_addr[63:32];
      q[m].push_back(mk({pcie_id, rr_tag, 8'hFF, 2'b00, h4, 19'd0, 10'(RR_DW)}, 0, 0, 0));
      q[m].push_back(mk(h4 ? {rr_addr[31:0], rr_addr[63:32]} : {32'd0, rr_addr[31:0]}, 1, !h4, 2));
    end else begin
      h4 = |wr_addr[63:32];
      q[m].push_back(mk({pcie_id, 16'h00FF, 2'b01, h4, 19'd0, 10'(WR_DW)}, 0, 0, 0));
      if (h4) begin
        q[m].push_back(mk({wr_addr[31:0], wr_addr[63:32]}, 0, 0, 0));
        for (int k = 0; k < n; k++) begin
          d = wr_tab[(widx[m] + k) % 8];
          q[m].push_back(mk({es(d[63:32]), es(d[31:0])}, k == n - 1, 0, 3));
        end
      end else begin
        for (int k = 0; k < n; k++) begin
          d = wr_tab[(widx[m] + k) % 8];
          q[m].push_back(mk({es(d[31:0]), k == 0 ? wr_addr[31:0] : es(p[63:32])}, 0, 0, 3));
          p = d;
        end
        q[m].push_back(mk({32'd0, es(p[63:32])}, 1, 1, 0));
      end
      widx[m] += n;
    end
    if (m == 1) prio[1] = (g + 1) % 3;
  endtask

  always @(negedge clock) begin
    logic adv;
    beat_t nx;
    logic [1:0] er;
    for (int m = 0; m < 2; m++) begin
      if (!reset_n) begin
        q[m].delete();
        cur[m] = '0;
        prio[m] = 0;
        sop[m] = 1'b1;
      end
      chk($sformatf("u%0d beat", m), {td[m], tv[m], tl[m], t1[m]}, {cur[m].d, cur[m].v, cur[m].l, cur[m].o});
      nx = cur[m];
      er = 2'd0;
      adv = tx_tready | ~cur[m].v;
      if (reset_n && adv) begin
        if (q[m].size() == 0 && {wr_valid, rr_valid, rc_valid} != 3'b0) build(m, pick(m));
        nx = q[m].size() != 0 ? q[m].pop_front() : '0;
        er = nx.r;
      end
      chk($sformatf("u%0d ready", m), {rcr[m], rrr[m], wrr[m]}, {er == 2'd1, er == 2'd2, er == 2'd3});
      if (reset_n && tv[m] && tx_tready) begin
        if (m == 0) begin
          acc.push_back(td[0]);
          accf.push_back({tl[0], t1[0]});
        end
        if (sop[m]) begin
          if (m == 0) hdr0.push_back(td[0][31:0]);
          else hdr1.push_back(td[1][31:0]);
        end
        sop[m] = tl[m];
      end
      if (m == 0 && reset_n) begin
        nrc += int'(rcr[0]);
        nrr += int'(rrr[0]);
        nwr += int'(wrr[0]);
      end
      cur[m] = nx;
    end
    take = wrr[0];
  end

  always @(posedge clock) begin
    #1;
    if (take) drv_idx++;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wait_rdy(input int src, input string nm);
    logic seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      @(negedge clock);
      seen = src == 0 ? rcr[0] : src == 1 ? rrr[0] : wrr[0];
    end
    tests++;
    if (!seen) begin
      fail++;
      $display("FAIL %s: ready timeout got 0 want 1", nm);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic clr();
    acc.delete();
    accf.delete();
    hdr0.delete();
    hdr1.delete();
    nrc = 0;
    nrr = 0;
    nwr = 0;
  endtask

  task automatic wr_setup();
    wr_tab[0] = 64'h0000000200000001;
    wr_tab[1] = 64'h0000000400000003;
    wr_addr = 64'h1000;
    drv_idx = 0;
    widx[0] = 0;
    widx[1] = 0;
    clr();
  endtask

  task automatic wr_expect(input string nm);
    chk({nm, " n"}, acc.size(), 4);
    chk({nm, " b0"}, acc[0], {16'h0100, 16'h00FF, 32'h40000004});
    chk({nm, " b1"}, acc[1], 64'h01000000_00001000);
    chk({nm, " b2"}, acc[2], 64'h03000000_02000000);
    chk({nm, " b3"}, acc[3], 64'h00000000_04000000);
    chk({nm, " f2"}, accf[2], 2'b00);
    chk({nm, " f3"}, accf[3], 2'b11);
    chk({nm, " wr_ready"}, nwr, 2);
  endtask

  initial begin
    int idle0, idle1;
    for (int i = 0; i < 8; i++) wr_tab[i] = '0;
    widx[0] = 0;
    widx[1] = 0;
    repeat (2) @(negedge clock);
    for (int m = 0; m < 2; m++) chk($sformatf("u%0d reset", m), {td[m], tv[m], tl[m], t1[m]}, 67'd0);
    cyc(1);
    reset_n = 1'b1;
    cyc(2);
    // single completion
    clr();
    rc_data = 64'h1122334455667788;
    rc_rid_tag = 24'hABCDEF;
    rc_lower_addr = 4'h5;
    rc_valid = 1'b1;
    wait_rdy(0, "rc");
    rc_valid = 1'b0;
    cyc(4);
    chk("rc n", acc.size(), 3);
    chk("rc b0", acc[0], 64'h0100_0008_4A000002);
    chk("rc b1", acc[1], 64'h88776655_ABCDEF28);
    chk("rc b2", acc[2], 64'h00000000_44332211);
    chk("rc f1", accf[1], 2'b00);
    chk("rc f2", accf[2], 2'b11);
    chk("rc ready", nrc, 1);
    // 4DW read request
    clr();
    rr_addr = 64'h1_0000_2000;
    rr_tag = 8'h07;
    rr_valid = 1'b1;
    wait_rdy(1, "rr");
    rr_valid = 1'b0;
    cyc(4);
    chk("rr n", acc.size(), 2);
    chk("rr b0", acc[0], 64'h0100_07FF_20000080);
    chk("rr b1", acc[1], 64'h00002000_00000001);
    chk("rr f1", accf[1], 2'b10);
    // 3DW write
    wr_setup();
    wr_valid = 1'b1;
    wait_rdy(2, "wr d0");
    wait_rdy(2, "wr d1");
    wr_valid = 1'b0;
    cyc(6);
    wr_expect("wr");
    // same write under alternating backpressure
    wr_setup();
    wr_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tx_tready = i[0];
      if (nwr == 2) wr_valid = 1'b0;
      cyc(1);
    end
    wr_valid = 1'b0;
    tx_tready = 1'b1;
    cyc(2);
    wr_expect("bp");
    // all three requesting continuously
    for (int i = 0; i < 8; i++) wr_tab[i] = 64'hDEADBEEF_CAFEF00D;
    clr();
    wr_addr = 64'h1000;
    rc_valid = 1'b1;
    rr_valid = 1'b1;
    wr_valid = 1'b1;
    cyc(1);
    idle0 = 0;
    idle1 = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      idle0 += int'(!tv[0]);
      idle1 += int'(!tv[1]);
    end
    cyc(1);
    rc_valid = 1'b0;
    rr_valid = 1'b0;
    wr_valid = 1'b0;
    cyc(10);
    chk("arb0 idle", idle0, 0);
    chk("arb1 idle", idle1, 0);
    chk("arb0 h0", hdr0[0], 32'h4A000002);
    chk("arb0 h1", hdr0[1], 32'h4A000002);
    chk("arb0 h2", hdr0[2], 32'h4A000002);
    chk("arb1 h0", hdr1[0], 32'h4A000002);
    chk("arb1 h1", hdr1[1], 32'h20000080);
    chk("arb1 h2", hdr1[2], 32'h40000004);
    chk("arb1 h3", hdr1[3], 32'h4A000002);
    // reset during write beat 3, then a clean 3DW read
    wr_setup();
    wr_valid = 1'b1;
    wait_rdy(2, "rst d0");
    wait_rdy(2, "rst d1");
    reset_n = 1'b0;
    wr_valid = 1'b0;
    @(negedge clock);
    chk("rst out", {td[0], tv[0], tl[0], t1[0]}, 67'd0);
    cyc(2);
    clr();
    rr_addr = 64'h3000;
    rr_tag = 8'h09;
    rr_valid = 1'b1;
    reset_n = 1'b1;
    wait_rdy(1, "rst rr");
    rr_valid = 1'b0;
    cyc(4);
    chk("rst rr n", acc.size(), 2);
    chk("rst rr b0", acc[0], {16'h0100, 8'h09, 8'hFF, 32'h00000080});
    chk("rst rr b1", acc[1], 64'h00000000_00003000);
    chk("rst rr f1", accf[1], 2'b11);
    $display("[TB] %0d tests run, %0d failed", tests, fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/pcie_tx_arb.md
Name: pcie_tx_arb

Overview:
- Parametrised successor to the single-format PCIe transmit formatter: merges three requesters (read completion, read request, posted write) into TLPs on a 64-bit AXI stream toward the PCIe core.
- Adds configurable write payload and read-request lengths, selectable arbitration (fixed priority or round-robin), and zeroed unused lanes.
- Sits between the DMA engines and the PCIe hard-core TX port.

Parameters:
- WR_PAYLOAD_DW, 32, write payload length in DW; even, 2..1024; 1024 encodes as length field 0.
- RR_LENGTH_DW, 128, read request length in DW; 1..1024; 1024 encodes as 0.
- ARB_MODE, 0, 0 = fixed priority rc>rr>wr, 1 = round-robin.

Ports:
- clock input 1 clock.
- reset_n input 1 reset; asynchronous, active-low.
- pcie_id input 16 requester/completer ID.
- rc_valid input 1; rc_rid_tag input 24 {requester ID, tag}; rc_lower_addr input 4 byte-address bits [6:3]; rc_data input 64; rc_ready output 1.
- rr_valid input 1; rr_addr input 64; rr_tag input 8; rr_ready output 1.
- wr_valid input 1; wr_addr input 64; wr_data input 64; wr_ready output 1.
- tx_tready input 1; tx_tdata output 64; tx_1dw output 1 (last beat carries only DW in [31:0]); tx_tlast output 1; tx_tvalid output 1.

Behaviour:
- Reset (async assert, sync release): tx_tdata=0, tx_tvalid=0, tx_tlast=0, tx_1dw=0, FSM IDLE, round-robin pointer=rc.
- adv = tx_tready | ~tx_tvalid. Output registers load only when adv. *_ready are combinational: adv && FSM in the consuming state.
- IDLE emits tx_tvalid=0, tdata=0. Arbitration occurs in IDLE and on the last beat of a TLP, giving back-to-back TLPs with no idle beat.
- ARB_MODE 1: priority starts one past the last granted source.
- Lane order: DW0 in [31:0]. Payload DWs are byte-swapped (es).
- Address width: addr[63:32]==0 selects a 3DW header, else 4DW.
- Unused upper lane on tx_1dw beats is 0.
- RC TLP, 3 beats; rc_ready on beat 3:
  - Beat 1: DW0 0x4A000002, DW1 {pcie_id, 16'd8}.
  - Beat 2: DW2 {rc_rid_tag, 1'b0, rc_lower_addr, 3'b0}, DW3 es(rc_data[31:0]).
  - Beat 3: es(rc_data[63:32]), tx_1dw=1, tlast=1.
- RR TLP, 2 beats; rr_ready on beat 2:
  - Beat 1: DW0 {3'b0, 4DW bit at [29], 19'b0, len[9:0]}, DW1 {pcie_id, rr_tag, 8'hFF}.
  - Beat 2 (3DW): addr[31:0] in DW2, upper lane 0, tx_1dw=1.
  - Beat 2 (4DW): {addr[31:0], addr[63:32]}.
  - tlast=1.
- WR TLP; N = WR_PAYLOAD_DW/2; wr_ready on every beat that consumes wr_data; wr_addr is held stable by the producer for the whole TLP.
  - Beat 1: DW0 {2'b01, 4DW bit, ..., len}, DW1 {pcie_id, 16'h00FF}.
  - 3DW: N+2 beats total.
    - Beat 2 = {es(d0.lo), addr[31:0]}.
    - Beats 3..N+1 = {es(dk.lo), es(dk-1.hi)}.
    - Beat N+2 = {0, es(dN-1.hi)}, tx_1dw=1.
    - Data is consumed on beats 2..N+1; the high half is held in a 32-bit register.
  - 4DW: N+2 beats total.
    - Beat 2 = {addr[31:0], addr[63:32]}.
    - Beats 3..N+2 = {es(d.hi), es(d.lo)}.
    - Data is consumed on beats 3..N+2; tx_1dw=0.
  - tlast on the final beat.
- Producer contract: once wr_valid is granted, every wr_ready cycle has valid wr_data. rc and rr inputs remain stable until their ready.
- Backpressure: while tx_tready=0 and tx_tvalid=1, outputs, FSM and counters hold, and all ready outputs are 0.
- Beat counter is 10 bits and resets at each header.
- Reset mid-TLP aborts immediately. No partial TLP resumes.
- Requests are granted only at a TLP boundary. A request arriving mid-TLP waits.

Test Plan:
- Single RC: rc_data=64'h1122334455667788, rid_tag=24'hABCDEF, lower_addr=4'h5, pcie_id=16'h0100 -> beats 64'h0100_0008_4A000002, 64'h88776655_ABCDEF28, 64'h0000_0000_44332211; tlast and 1dw set on beat 3; rc_ready one cycle.
- RR 4DW: addr 64'h1_0000_2000, tag 8'h07, RR_LENGTH_DW=128 -> beat 1 64'h0100_07FF_20000080, beat 2 64'h00002000_00000001, tlast set, tx_1dw=0.
- WR 3DW, WR_PAYLOAD_DW=4, addr 32'h1000, data d0=64'h0000000200000001, d1=64'h0000000400000003 -> 4 beats: header, {01000000, 00001000}, {03000000, 02000000}, {0, 04000000} with 1dw; wr_ready exactly 2 cycles.
- Backpressure: tx_tready toggled 1010… during the WR from the previous scenario -> identical beat sequence, no beat lost or duplicated, wr_ready only on accepted beats.
- Arbitration, all three valid continuously: ARB_MODE 0 -> rc, rc, rc…; ARB_MODE 1 -> rc, rr, wr, rc… back-to-back with no idle beats.
- reset_n asserted mid-WR beat 3 -> outputs 0 immediately; after release with only rr_valid=1, a clean RR TLP is emitted.
